// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit.
// funct3 op codes, decode funct7, FSM state encoding and operand sign helpers.
package muldiv_unit_pkg;

    localparam logic [2:0] MULDIV_MUL    = 3'b000;
    localparam logic [2:0] MULDIV_MULH   = 3'b001;
    localparam logic [2:0] MULDIV_MULHSU = 3'b010;
    localparam logic [2:0] MULDIV_MULHU  = 3'b011;
    localparam logic [2:0] MULDIV_DIV    = 3'b100;
    localparam logic [2:0] MULDIV_DIVU   = 3'b101;
    localparam logic [2:0] MULDIV_REM    = 3'b110;
    localparam logic [2:0] MULDIV_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

    function automatic logic signed_a(input logic [2:0] f);
        return (f == MULDIV_MULH) || (f == MULDIV_MULHSU) ||
               (f == MULDIV_DIV) || (f == MULDIV_REM);
    endfunction

    function automatic logic signed_b(input logic [2:0] f);
        return (f == MULDIV_MULH) || (f == MULDIV_DIV) ||
               (f == MULDIV_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result handshake bundle between EX control and the muldiv unit.
// master = pipeline side, slave = muldiv_unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start_valid;
    logic            start_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            result_valid;
    logic            result_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output start_valid, funct3, op_a, op_b, flush, result_ready,
        input  start_ready, result_valid, result, busy
    );

    modport slave (
        input  start_valid, funct3, op_a, op_b, flush, result_ready,
        output start_ready, result_valid, result, busy
    );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: operand magnitude on entry,
// sign application on the FIX path.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);
    assign res = neg ? (~val + W'(1)) : val;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit (shift-add MUL, restoring DIV).
// Build option MULDIV_EARLY_OUT_EN: specials jump straight from IDLE to DONE.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam int W2    = 2 * XLEN;

    state_t            state, state_nxt;
    logic [2:0]        op;
    logic              sa, sb, bz;
    logic [XLEN-1:0]   b_mag;
    logic [W2-1:0]     prod;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   result;

    logic              accept;
    logic              a_neg_in, b_neg_in, b_zero_in;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic [XLEN:0]     add_sum, sub_diff;
    logic [W2-1:0]     prod_step;
    logic              rem_op, fix_neg;
    logic [W2-1:0]     fix_in, fix_out;
    logic [XLEN-1:0]   fix_word;
    logic              early;
    logic [XLEN-1:0]   early_res;

    assign accept    = (state == IDLE) && bus.start_valid && !bus.flush;
    assign a_neg_in  = signed_a(bus.funct3) && bus.op_a[XLEN-1];
    assign b_neg_in  = signed_b(bus.funct3) && bus.op_b[XLEN-1];
    assign b_zero_in = (bus.op_b == '0);

    muldiv_signfix #(.W(XLEN)) u_fix_a (
        .val(bus.op_a), .neg(a_neg_in), .res(a_abs)
    );
    muldiv_signfix #(.W(XLEN)) u_fix_b (
        .val(bus.op_b), .neg(b_neg_in), .res(b_abs)
    );

    // prod holds {hi, lo} for multiply and {remainder, quotient} for divide
    assign add_sum  = {1'b0, prod[W2-1:XLEN]}
                    + {1'b0, (prod[0] ? b_mag : {XLEN{1'b0}})};
    assign sub_diff = prod[W2-1:XLEN-1] - {1'b0, b_mag};

    always_comb begin
        prod_step = {add_sum, prod[XLEN-1:1]};
        if (is_div(op)) begin
            if (sub_diff[XLEN])
                prod_step = {prod[W2-2:0], 1'b0};
            else
                prod_step = {sub_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
        end
    end

    // A zero divisor keeps the all-ones quotient unsigned
    assign rem_op  = op[1];
    always_comb begin
        fix_in  = prod;
        fix_neg = sa ^ sb;
        if (is_div(op)) begin
            if (rem_op) begin
                fix_in  = {{XLEN{1'b0}}, prod[W2-1:XLEN]};
                fix_neg = sa;
            end else begin
                fix_in  = {{XLEN{1'b0}}, prod[XLEN-1:0]};
                fix_neg = (sa ^ sb) && !bz;
            end
        end
    end

    muldiv_signfix #(.W(W2)) u_fix_res (
        .val(fix_in), .neg(fix_neg), .res(fix_out)
    );

    assign fix_word = (is_div(op) || op == MULDIV_MUL) ?
                      fix_out[XLEN-1:0] : fix_out[W2-1:XLEN];

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
    logic ovf_in;
    assign ovf_in = (bus.funct3 == MULDIV_DIV || bus.funct3 == MULDIV_REM)
                  && (bus.op_a == MIN_VAL) && (&bus.op_b);
    always_comb begin
        early     = 1'b0;
        early_res = '0;
        if (is_div(bus.funct3)) begin
            if (b_zero_in) begin
                early     = 1'b1;
                early_res = bus.funct3[1] ? bus.op_a : '1;
            end else if (ovf_in) begin
                early     = 1'b1;
                early_res = bus.funct3[1] ? '0 : bus.op_a;
            end
        end else if (bus.op_a == '0 || b_zero_in) begin
            early = 1'b1;
        end
    end
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = early ? DONE : CALC;
            CALC: begin
                if (bus.flush)
                    state_nxt = IDLE;
                else if (cnt == CNT_W'(1))
                    state_nxt = FIX;
            end
            FIX:  state_nxt = bus.flush ? IDLE : DONE;
            DONE: if (bus.flush || bus.result_ready) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            op     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            bz     <= 1'b0;
            b_mag  <= '0;
            prod   <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (accept) begin
                    op    <= bus.funct3;
                    sa    <= a_neg_in;
                    sb    <= b_neg_in;
                    bz    <= b_zero_in;
                    b_mag <= b_abs;
                    prod  <= {{XLEN{1'b0}}, a_abs};
                    cnt   <= CNT_W'(XLEN);
                    if (early) result <= early_res;
                end
                CALC: if (!bus.flush) begin
                    prod <= prod_step;
                    cnt  <= cnt - CNT_W'(1);
                end
                FIX:  if (!bus.flush) result <= fix_word;
                DONE: ;
            endcase
        end
    end

    assign bus.start_ready  = (state == IDLE);
    assign bus.result_valid = (state == DONE);
    assign bus.busy         = (state != IDLE);
    assign bus.result       = result;

endmodule
